uart_tx_buffer: RTL



---
 rtl/uart_tx_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// FIFO-buffered launcher for a UART transmitter: words queue on valid and are handed out one per frame.
// Latency: 2 cycles from push to o_tx_en when idle; backpressure via o_ready (=!o_full), overflow is sticky.
module uart_tx_buffer #(
  parameter int G_WORD_WIDTH   = 8,
  parameter int G_DEPTH        = 16,
  parameter int G_BUSY_TIMEOUT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [G_WORD_WIDTH-1:0]    i_data,
  output logic                       o_ready,
  output logic                       o_tx_en,
  output logic [G_WORD_WIDTH-1:0]    o_tx_data,
  input  logic                       i_tx_busy,
  output logic [$clog2(G_DEPTH):0]   o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic                       o_tx_err
);

  localparam int AW = $clog2(G_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(G_BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count_n;
  logic [TW-1:0]           tcnt;
  logic [TW-1:0]           tcnt_n;
  logic                    push;
  logic                    launch;
  logic                    err_set;
  logic                    head_vld;
  logic [G_WORD_WIDTH-1:0] rd_data;
  logic [G_WORD_WIDTH-1:0] mem [G_DEPTH];

  assign o_ready = !o_full && !i_rst;
  assign push    = i_valid && !o_full;

  // Storage has a registered read port; head_vld holds off a launch until a
  // word written into an empty buffer has propagated through rd_data.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
    rd_data <= mem[rd_ptr];
  end

  always_comb begin
    count_n = o_count;
    if (push && !launch) begin
      count_n = o_count + CW'(1);
    end else if (!push && launch) begin
      count_n = o_count - CW'(1);
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    launch  = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (!o_empty && head_vld && !i_tx_busy) begin
          launch  = 1'b1;
          tcnt_n  = '0;
          state_n = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_n = WAIT_DONE;
        end else if (tcnt == TW'(G_BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: the popped word is dropped.
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_empty    <= 1'b1;
      o_full     <= 1'b0;
      head_vld   <= 1'b0;
      o_tx_en    <= 1'b0;
      o_tx_data  <= '0;
      o_overflow <= 1'b0;
      o_tx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      tcnt     <= tcnt_n;
      o_tx_en  <= launch;
      o_count  <= count_n;
      o_empty  <= (count_n == '0);
      o_full   <= (count_n == CW'(G_DEPTH));
      head_vld <= !o_empty;
      if (launch) begin
        o_tx_data <= rd_data;
        rd_ptr    <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (i_valid && o_full) begin
        o_overflow <= 1'b1;
      end
      if (err_set) begin
        o_tx_err <= 1'b1;
      end
    end
  end

endmodule
